// File: rtl/lc3_mmio_responder.sv
// rtl/lc3_mmio_responder.sv - LC-3 keyboard/display memory-mapped register responder
//
// Purpose: device end of the LC-3 memory bus. Answers MAR/MDR loads and stores to
// KBSR, KBDR, DSR and DDR. Keyboard bytes are buffered in a small FIFO fed by a
// valid/ready stream. Display bytes leave on a valid/ready stream.
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-low reset
//   bus_addr, bus_wdata             MAR / MDR
//   bus_we, bus_re                  one-cycle store / load strobes
//   bus_rdata, bus_ack              registered load data and ack, one cycle after the strobe
//   bus_hit                         combinational decode of the four register addresses
//   kb_valid, kb_data, kb_ready     keyboard byte stream in
//   dsp_valid, dsp_data, dsp_ready  display byte stream out
//   kb_irq                          registered KBSR[15] & KBSR[14]
module lc3_mmio_responder #(
  parameter logic [15:0] BASE_ADDR = 16'hFE00,
  parameter int          KB_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_addr,
  input  logic [15:0] bus_wdata,
  input  logic        bus_we,
  input  logic        bus_re,
  output logic [15:0] bus_rdata,
  output logic        bus_ack,
  output logic        bus_hit,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_ready,
  output logic        dsp_valid,
  output logic [7:0]  dsp_data,
  input  logic        dsp_ready,
  output logic        kb_irq
);

  localparam int PW = $clog2(KB_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [KB_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ie_q, ie_d;
  logic          ovr_q, ovr_d;
  logic          dsp_valid_q, dsp_valid_d;
  logic [7:0]    dsp_data_q, dsp_data_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic          irq_q, irq_d;

  logic sel_kbsr, sel_kbdr, sel_dsr, sel_ddr;
  logic is_load, is_store;
  logic ne, full, push, pop;

  // Full 16-bit compare: odd offsets and aliases never hit.
  assign sel_kbsr = (bus_addr == BASE_ADDR);
  assign sel_kbdr = (bus_addr == BASE_ADDR + 16'd2);
  assign sel_dsr  = (bus_addr == BASE_ADDR + 16'd4);
  assign sel_ddr  = (bus_addr == BASE_ADDR + 16'd6);
  assign bus_hit  = sel_kbsr | sel_kbdr | sel_dsr | sel_ddr;

  // A store with a simultaneous load wins; the load side is dropped entirely.
  assign is_store = bus_we & bus_hit;
  assign is_load  = bus_re & ~bus_we & bus_hit;

  assign ne       = (cnt_q != '0);
  assign full     = (cnt_q == CW'(KB_DEPTH));
  assign kb_ready = ~full;
  assign push     = kb_valid & ~full;
  assign pop      = is_load & sel_kbdr & ne;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    ie_d        = ie_q;
    ovr_d       = ovr_q;
    dsp_valid_d = dsp_valid_q;
    dsp_data_d  = dsp_data_q;
    rdata_d     = 16'h0000;
    ack_d       = is_store | is_load;

    // Status reads use pre-edge state.
    if (is_load) begin
      if (sel_kbsr)                rdata_d = {ne, ie_q, 14'b0};
      else if (sel_kbdr && ne)     rdata_d = {8'h00, mem_q[rptr_q]};
      else if (sel_dsr)            rdata_d = {~dsp_valid_q, 1'b0, ovr_q, 13'b0};
    end

    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (is_store && sel_kbsr) ie_d  = bus_wdata[14];
    if (is_store && sel_dsr)  ovr_d = 1'b0;

    if (dsp_valid_q && dsp_ready) dsp_valid_d = 1'b0;
    // A byte leaving on the same edge frees the slot for the incoming store.
    if (is_store && sel_ddr) begin
      if (!dsp_valid_q || dsp_ready) begin
        dsp_data_d  = bus_wdata[7:0];
        dsp_valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    irq_d = ie_d & (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      ie_q        <= 1'b0;
      ovr_q       <= 1'b0;
      dsp_valid_q <= 1'b0;
      dsp_data_q  <= 8'h00;
      rdata_q     <= 16'h0000;
      ack_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      ie_q        <= ie_d;
      ovr_q       <= ovr_d;
      dsp_valid_q <= dsp_valid_d;
      dsp_data_q  <= dsp_data_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      irq_q       <= irq_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wptr_q] <= kb_data;
  end

  assign bus_rdata = rdata_q;
  assign bus_ack   = ack_q;
  assign dsp_valid = dsp_valid_q;
  assign dsp_data  = dsp_data_q;
  assign kb_irq    = irq_q;

endmodule

// File: tb/tb_lc3_mmio_responder.sv
// tb/tb_lc3_mmio_responder.sv - directed self-checking bench for lc3_mmio_responder
module tb_lc3_mmio_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] bus_addr = 16'h0000;
  logic [15:0] bus_wdata = 16'h0000;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [15:0] bus_rdata;
  logic        bus_ack;
  logic        bus_hit;
  logic        kb_valid = 1'b0;
  logic [7:0]  kb_data = 8'h00;
  logic        kb_ready;
  logic        dsp_valid;
  logic [7:0]  dsp_data;
  logic        dsp_ready = 1'b0;
  logic        kb_irq;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] r_data;
  logic        r_ack;
  logic        r_hit;

  localparam logic [15:0] KBSR = 16'hFE00;
  localparam logic [15:0] KBDR = 16'hFE02;
  localparam logic [15:0] DSR  = 16'hFE04;
  localparam logic [15:0] DDR  = 16'hFE06;

  lc3_mmio_responder dut (
    .clk(clk), .reset(reset),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_hit(bus_hit),
    .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
    .dsp_valid(dsp_valid), .dsp_data(dsp_data), .dsp_ready(dsp_ready),
    .kb_irq(kb_irq)
  );

  always #5 clk = ~clk;

  // One bus access: strobe across one rising edge, capture ack/rdata just after it.
  task automatic bus_op(input logic [15:0] a, input logic [15:0] wd, input logic we, input logic re);
    @(negedge clk);
    bus_addr = a; bus_wdata = wd; bus_we = we; bus_re = re;
    #1 r_hit = bus_hit;
    @(posedge clk);
    #1;
    r_ack = bus_ack; r_data = bus_rdata;
    bus_we = 1'b0; bus_re = 1'b0; bus_addr = 16'h0000; bus_wdata = 16'h0000;
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    kb_valid = 1'b1; kb_data = b;
    @(posedge clk);
    #1 kb_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; kb_valid = 1'b1; kb_data = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus_rdata !== 16'h0000) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0000", bus_rdata); end
    n_cmp++; if (bus_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%b exp=0", bus_ack); end
    n_cmp++; if (dsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dsp_valid got=%b exp=0", dsp_valid); end
    n_cmp++; if (dsp_data !== 8'h00) begin n_bad++; $display("FAIL reset_dsp_data got=%h exp=00", dsp_data); end
    n_cmp++; if (kb_irq !== 1'b0) begin n_bad++; $display("FAIL reset_kb_irq got=%b exp=0", kb_irq); end
    n_cmp++; if (kb_ready !== 1'b1) begin n_bad++; $display("FAIL reset_kb_ready got=%b exp=1", kb_ready); end
    kb_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    bus_op(KBSR, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (r_ack !== 1'b1 || r_data !== 16'h0000) begin n_bad++; $display("FAIL reset_fifo_empty ack=%b data=%h exp ack=1 data=0000", r_ack, r_data); end
  endtask

  task automatic test_kb_basic;
    push_byte(8'h41);
    push_byte(8'h42);
    bus_op(KBSR, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (r_data !== 16'h8000) begin n_bad++; $display("FAIL kbsr_ne got=%h exp=8000", r_data); end
    bus_op(KBDR, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (r_data !== 16'h0041) begin n_bad++; $display("FAIL kbdr_1 got=%h exp=0041", r_data); end
    bus_op(KBDR, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (r_data !== 16'h0042) begin n_bad++; $display("FAIL kbdr_2 got=%h exp=0042", r_data); end
    bus_op(KBSR, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (r_data !== 16'h0000) begin n_bad++; $display("FAIL kbsr_empty got=%h exp=0000", r_data); end
    bus_op(KBDR, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (r_ack !== 1'b1 || r_data !== 16'h0000) begin n_bad++; $display("FAIL kbdr_empty ack=%b data=%h exp ack=1 data=0000", r_ack, r_data); end
  endtask

  task automatic test_fifo_full_wrap;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h11; exp_b[1] = 8'h12; exp_b[2] = 8'h13; exp_b[3] = 8'h14;
    for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i));
    n_cmp++; if (kb_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got=%b exp=0", kb_ready); end
    @(negedge clk);
    kb_valid = 1'b1; kb_data = 8'h14;
    @(posedge clk); #1;
    n_cmp++; if (kb_ready !== 1'b0) begin n_bad++; $display("FAIL full_hold got=%b exp=0", kb_ready); end
    bus_op(KBDR, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (r_data !== 16'h0010) begin n_bad++; $display("FAIL wrap_pop0 got=%h exp=0010", r_data); end
    n_cmp++; if (kb_ready !== 1'b1) begin n_bad++; $display("FAIL after_pop_ready got=%b exp=1", kb_ready); end
    @(posedge clk); #1;
    kb_valid = 1'b0;
    n_cmp++; if (kb_ready !== 1'b0) begin n_bad++; $display("FAIL refull_ready got=%b exp=0", kb_ready); end
    for (int i = 0; i < 4; i++) begin
      bus_op(KBDR, 16'h0, 1'b0, 1'b1);
      n_cmp++; if (r_data !== {8'h00, exp_b[i]}) begin n_bad++; $display("FAIL wrap_pop%0d got=%h exp=%h", i + 1, r_data, {8'h00, exp_b[i]}); end
    end
    bus_op(KBSR, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (r_data !== 16'h0000) begin n_bad++; $display("FAIL wrap_empty got=%h exp=0000", r_data); end
  endtask

  task automatic test_irq;
    bus_op(KBSR, 16'h4000, 1'b1, 1'b0);
    n_cmp++; if (r_ack !== 1'b1 || kb_irq !== 1'b0) begin n_bad++; $display("FAIL irq_ie_empty ack=%b irq=%b exp ack=1 irq=0", r_ack, kb_irq); end
    push_byte(8'h77);
    n_cmp++; if (kb_irq !== 1'b1) begin n_bad++; $display("FAIL irq_set got=%b exp=1", kb_irq); end
    bus_op(KBSR, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (r_data !== 16'hC000) begin n_bad++; $display("FAIL irq_kbsr got=%h exp=c000", r_data); end
    bus_op(KBDR, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (r_data !== 16'h0077) begin n_bad++; $display("FAIL irq_pop got=%h exp=0077", r_data); end
    n_cmp++; if (kb_irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear got=%b exp=0", kb_irq); end
    bus_op(KBSR, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_display;
    dsp_ready = 1'b0;
    bus_op(DDR, 16'h0058, 1'b1, 1'b0);
    n_cmp++; if (dsp_valid !== 1'b1 || dsp_data !== 8'h58) begin n_bad++; $display("FAIL ddr_store valid=%b data=%h exp valid=1 data=58", dsp_valid, dsp_data); end
    bus_op(DDR, 16'h0059, 1'b1, 1'b0);
    n_cmp++; if (dsp_data !== 8'h58) begin n_bad++; $display("FAIL ddr_hold got=%h exp=58", dsp_data); end
    bus_op(DSR, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (r_data !== 16'h2000) begin n_bad++; $display("FAIL dsr_ovr got=%h exp=2000", r_data); end
    @(negedge clk) dsp_ready = 1'b1;
    @(posedge clk); #1;
    dsp_ready = 1'b0;
    n_cmp++; if (dsp_valid !== 1'b0) begin n_bad++; $display("FAIL dsp_drain got=%b exp=0", dsp_valid); end
    bus_op(DSR, 16'h0000, 1'b1, 1'b0);
    bus_op(DSR, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (r_data !== 16'h8000) begin n_bad++; $display("FAIL dsr_clear got=%h exp=8000", r_data); end
    bus_op(DDR, 16'h0060, 1'b1, 1'b0);
    dsp_ready = 1'b1;
    bus_op(DDR, 16'h0061, 1'b1, 1'b0);
    dsp_ready = 1'b0;
    n_cmp++; if (dsp_valid !== 1'b1 || dsp_data !== 8'h61) begin n_bad++; $display("FAIL ddr_handoff valid=%b data=%h exp valid=1 data=61", dsp_valid, dsp_data); end
    bus_op(DSR, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (r_data !== 16'h0000) begin n_bad++; $display("FAIL dsr_no_ovr got=%h exp=0000", r_data); end
    bus_op(DDR, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (r_ack !== 1'b1 || r_data !== 16'h0000) begin n_bad++; $display("FAIL ddr_load ack=%b data=%h exp ack=1 data=0000", r_ack, r_data); end
    @(negedge clk) dsp_ready = 1'b1;
    @(posedge clk); #1 dsp_ready = 1'b0;
  endtask

  task automatic test_we_re_and_decode;
    push_byte(8'h33);
    bus_op(KBDR, 16'h1234, 1'b1, 1'b1);
    n_cmp++; if (r_ack !== 1'b1 || r_data !== 16'h0000) begin n_bad++; $display("FAIL we_re ack=%b data=%h exp ack=1 data=0000", r_ack, r_data); end
    @(posedge clk); #1;
    n_cmp++; if (bus_ack !== 1'b0) begin n_bad++; $display("FAIL we_re_one_ack got=%b exp=0", bus_ack); end
    bus_op(KBSR, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (r_data !== 16'h8000) begin n_bad++; $display("FAIL we_re_no_pop got=%h exp=8000", r_data); end
    bus_op(16'hFE01, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (r_hit !== 1'b0 || r_ack !== 1'b0) begin n_bad++; $display("FAIL odd_addr hit=%b ack=%b exp hit=0 ack=0", r_hit, r_ack); end
    bus_op(16'hFE06, 16'h0, 1'b0, 1'b0);
    n_cmp++; if (r_hit !== 1'b1 || r_ack !== 1'b0) begin n_bad++; $display("FAIL ddr_decode hit=%b ack=%b exp hit=1 ack=0", r_hit, r_ack); end
    bus_op(KBDR, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (r_data !== 16'h0033) begin n_bad++; $display("FAIL we_re_pop got=%h exp=0033", r_data); end
  endtask

  initial begin
    test_reset();
    test_kb_basic();
    test_fifo_full_wrap();
    test_irq();
    test_display();
    test_we_re_and_decode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
